// File: rtl/xintf_ram_wr_arbiter.sv
// Round-robin arbiter sharing the XINTF DPBRAM write port among NUM_REQ burst writers.
// Optional XINTF_ARB_PRIORITY_EN: requester 0 wins every IDLE arbitration, others rotate.
module xintf_ram_wr_arbiter #(
  parameter int unsigned NUM_REQ   = 3,
  parameter int unsigned ADDR_W    = 9,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MAX_BURST = 64
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic [NUM_REQ-1:0]          i_req,
  input  logic [NUM_REQ-1:0]          i_we,
  input  logic [NUM_REQ-1:0]          i_last,
  input  logic [NUM_REQ*ADDR_W-1:0]   i_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   i_din,
  input  logic                        i_timeout_clr,
  output logic [NUM_REQ-1:0]          o_gnt,
  output logic [ADDR_W-1:0]           o_ram_addr,
  output logic [DATA_W-1:0]           o_ram_din,
  output logic                        o_ram_ce,
  output logic                        o_busy,
  output logic [NUM_REQ-1:0]          o_timeout
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_RELEASE} state_e;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [IDX_W-1:0]    gidx_q, gidx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   din_q, din_d;
  logic                ce_q, ce_d;
  logic                busy_q;
  logic [NUM_REQ-1:0]  to_q, to_d;

  logic                found;
  logic [IDX_W-1:0]    sel;
  logic                req_g, we_g, last_g;
  logic [ADDR_W-1:0]   addr_g;
  logic [DATA_W-1:0]   din_g;
  logic [CNT_W-1:0]    cnt_inc;

  // Arbitration pick and granted-requester mux
  always_comb begin
    int unsigned idx;
    found  = 1'b0;
    sel    = '0;
    idx    = 0;
    req_g  = 1'b0;
    we_g   = 1'b0;
    last_g = 1'b0;
    addr_g = '0;
    din_g  = '0;
`ifdef XINTF_ARB_PRIORITY_EN
    if (i_req[0]) begin
      found = 1'b1;
    end else begin
      int unsigned start;
      start = (ptr_q == '0) ? 1 : 32'(ptr_q);
      for (int unsigned i = 0; i < NUM_REQ - 1; i++) begin
        idx = start + i;
        if (idx >= NUM_REQ) idx = idx - (NUM_REQ - 1);
        if (!found && i_req[IDX_W'(idx)]) begin
          found = 1'b1;
          sel   = IDX_W'(idx);
        end
      end
    end
`else
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && i_req[IDX_W'(idx)]) begin
        found = 1'b1;
        sel   = IDX_W'(idx);
      end
    end
`endif
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (gidx_q == IDX_W'(k)) begin
        req_g  = i_req[k];
        we_g   = i_we[k];
        last_g = i_last[k];
        addr_g = i_addr[k*ADDR_W +: ADDR_W];
        din_g  = i_din[k*DATA_W +: DATA_W];
      end
    end
  end

  assign cnt_inc = cnt_q + CNT_W'(1);

  // Next-state and output logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gidx_d  = gidx_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    addr_d  = addr_q;
    din_d   = din_q;
    ce_d    = 1'b0;
    to_d    = i_timeout_clr ? '0 : to_q;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          gidx_d  = sel;
          gnt_d   = NUM_REQ'(1) << sel;
          cnt_d   = '0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (!req_g) begin
          gnt_d   = '0;
          state_d = ST_RELEASE;
        end else if (we_g) begin
          ce_d   = 1'b1;
          addr_d = addr_g;
          din_d  = din_g;
          cnt_d  = cnt_inc;
          if (last_g) begin
            gnt_d   = '0;
            state_d = ST_RELEASE;
          end else if (cnt_inc == CNT_W'(MAX_BURST)) begin
            gnt_d        = '0;
            to_d[gidx_q] = 1'b1;
            state_d      = ST_RELEASE;
          end
        end
      end
      ST_RELEASE: begin
        gnt_d   = '0;
        ptr_d   = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : gidx_q + IDX_W'(1);
        state_d = ST_IDLE;
      end
      default: begin
        gnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      gidx_q  <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      ce_q    <= 1'b0;
      busy_q  <= 1'b0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      ce_q    <= ce_d;
      busy_q  <= (state_d != ST_IDLE);
      to_q    <= to_d;
    end
  end

  assign o_gnt      = gnt_q;
  assign o_ram_addr = addr_q;
  assign o_ram_din  = din_q;
  assign o_ram_ce   = ce_q;
  assign o_busy     = busy_q;
  assign o_timeout  = to_q;

endmodule

// File: tb/tb_xintf_ram_wr_arbiter.sv
// Scoreboard bench for xintf_ram_wr_arbiter: queued expected writes/grants checked by a monitor.
// The priority scenario runs only when XINTF_ARB_PRIORITY_EN is defined.
module tb_xintf_ram_wr_arbiter;
  localparam int NR  = 3;
  localparam int AW  = 9;
  localparam int DW  = 16;
  localparam int MB  = 4;
  localparam int TCK = 10;

  localparam int K_GNT  = 0;
  localparam int K_CE   = 1;
  localparam int K_ADDR = 2;
  localparam int K_DIN  = 3;
  localparam int K_TO   = 4;
  localparam int K_BUSY = 5;
  localparam int K_VAL  = 6;

  logic             i_clk;
  logic             i_rst;
  logic [NR-1:0]    i_req;
  logic [NR-1:0]    i_we;
  logic [NR-1:0]    i_last;
  logic [NR*AW-1:0] i_addr;
  logic [NR*DW-1:0] i_din;
  logic             i_timeout_clr;
  logic [NR-1:0]    o_gnt;
  logic [AW-1:0]    o_ram_addr;
  logic [DW-1:0]    o_ram_din;
  logic             o_ram_ce;
  logic             o_busy;
  logic [NR-1:0]    o_timeout;

  xintf_ram_wr_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_we(i_we), .i_last(i_last),
    .i_addr(i_addr), .i_din(i_din), .i_timeout_clr(i_timeout_clr),
    .o_gnt(o_gnt), .o_ram_addr(o_ram_addr), .o_ram_din(o_ram_din),
    .o_ram_ce(o_ram_ce), .o_busy(o_busy), .o_timeout(o_timeout)
  );

  initial i_clk = 1'b0;
  always #(TCK/2) i_clk = ~i_clk;

  typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d;} wr_t;
  typedef struct packed {logic [NR-1:0] g; logic [7:0] gap;} gx_t;

  wr_t         wr_q[$];
  gx_t         g_q[$];
  string       sn_q[$];
  int          sk_q[$];
  logic [31:0] sa_q[$];
  logic [31:0] se_q[$];
  event        snap_ev;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic snap(input string nm, input int kind, input logic [31:0] act, input logic [31:0] exp);
    sn_q.push_back(nm);
    sk_q.push_back(kind);
    sa_q.push_back(act);
    se_q.push_back(exp);
    ->snap_ev;
  endtask

  // Monitor: point checks on demand, write/grant scoreboard on every falling edge
  initial begin
    logic [NR-1:0] prev_g;
    int            zc;
    wr_t           w;
    gx_t           ge;
    string         nm;
    int            k;
    logic [31:0]   act;
    logic [31:0]   ex;
    prev_g = '0;
    zc     = 0;
    forever begin
      @(negedge i_clk or snap_ev);
      while (sn_q.size() > 0) begin
        nm  = sn_q.pop_front();
        k   = sk_q.pop_front();
        act = sa_q.pop_front();
        ex  = se_q.pop_front();
        case (k)
          K_GNT:   act = 32'(o_gnt);
          K_CE:    act = 32'(o_ram_ce);
          K_ADDR:  act = 32'(o_ram_addr);
          K_DIN:   act = 32'(o_ram_din);
          K_TO:    act = 32'(o_timeout);
          K_BUSY:  act = 32'(o_busy);
          default: ;
        endcase
        n_cmp++;
        if (act !== ex) begin
          n_bad++;
          $display("FAIL %s: actual %0h required %0h", nm, act, ex);
        end
      end
      if (($time % TCK) == 0) begin
        if (i_rst) begin
          prev_g = '0;
          zc     = 0;
        end else begin
          if (o_ram_ce) begin
            n_cmp++;
            if (wr_q.size() == 0) begin
              n_bad++;
              $display("FAIL write_unexpected: actual addr %0h din %0h required no write", o_ram_addr, o_ram_din);
            end else begin
              w = wr_q.pop_front();
              if (o_ram_addr !== w.a || o_ram_din !== w.d) begin
                n_bad++;
                $display("FAIL write: actual addr %0h din %0h required addr %0h din %0h",
                         o_ram_addr, o_ram_din, w.a, w.d);
              end
            end
          end
          if (o_gnt != '0 && o_gnt != prev_g) begin
            n_cmp++;
            if (g_q.size() == 0) begin
              n_bad++;
              $display("FAIL grant_unexpected: actual %b required none", o_gnt);
            end else begin
              ge = g_q.pop_front();
              if (o_gnt !== ge.g) begin
                n_bad++;
                $display("FAIL grant_order: actual %b required %b", o_gnt, ge.g);
              end
              if (ge.gap != 8'd0) begin
                n_cmp++;
                if (zc != int'(ge.gap)) begin
                  n_bad++;
                  $display("FAIL grant_gap: actual %0d required %0d", zc, ge.gap);
                end
              end
            end
          end
          zc     = (o_gnt == '0) ? zc + 1 : 0;
          prev_g = o_gnt;
        end
      end
    end
  end

  task automatic wait_gnt(input int k, input int lat, input int gap);
    gx_t e;
    int  c;
    bit  ok;
    e.g   = NR'(1) << k;
    e.gap = 8'(gap);
    g_q.push_back(e);
    c  = 0;
    ok = 1'b0;
    while (!ok && c < 50) begin
      @(posedge i_clk); #1;
      c++;
      if (o_gnt[k]) ok = 1'b1;
    end
    if (!ok) snap("grant_wait_bound", K_GNT, 32'd0, 32'(e.g));
    else if (lat >= 0) snap("grant_latency", K_VAL, 32'(c), 32'(lat));
  endtask

  task automatic write_burst(input int k, input int n, input bit last,
                             input logic [AW-1:0] abase, input logic [DW-1:0] dbase);
    wr_t e;
    for (int j = 0; j < n; j++) begin
      e.a = abase + AW'(j);
      e.d = dbase + DW'(j);
      i_we[k]               = 1'b1;
      i_last[k]             = last && (j == n - 1);
      i_addr[k*AW +: AW]    = e.a;
      i_din[k*DW +: DW]     = e.d;
      wr_q.push_back(e);
      @(posedge i_clk); #1;
    end
    i_we[k]   = 1'b0;
    i_last[k] = 1'b0;
  endtask

  task automatic reset_pulse();
    i_rst = 1'b1;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1;
    i_req = '0;
    i_we = '0;
    i_last = '0;
    i_addr = '0;
    i_din = '0;
    i_timeout_clr = 1'b0;
    repeat (2) @(posedge i_clk);
    #1;
    snap("rst_gnt", K_GNT, 0, 0);
    snap("rst_ce", K_CE, 0, 0);
    snap("rst_addr", K_ADDR, 0, 0);
    snap("rst_din", K_DIN, 0, 0);
    snap("rst_timeout", K_TO, 0, 0);
    snap("rst_busy", K_BUSY, 0, 0);
    @(posedge i_clk); #1;
    i_rst = 1'b0;

    // Single requester, three-write burst
    i_req = 3'b001;
    wait_gnt(0, 1, 0);
    snap("busy_granted", K_BUSY, 0, 32'd1);
    write_burst(0, 3, 1'b1, 9'h000, 16'hA000);
    snap("gnt_after_last", K_GNT, 0, 0);
    i_req = '0;
    repeat (3) @(posedge i_clk);
    #1;
    reset_pulse();

    // All requesting: rotation 0,1,2,0 with two-cycle gaps
    i_req = 3'b111;
    wait_gnt(0, 1, 0);
    write_burst(0, 2, 1'b1, 9'h010, 16'hB000);
    wait_gnt(1, -1, 2);
    write_burst(1, 2, 1'b1, 9'h020, 16'hB100);
    wait_gnt(2, -1, 2);
    write_burst(2, 2, 1'b1, 9'h030, 16'hB200);
    wait_gnt(0, -1, 2);
    write_burst(0, 2, 1'b1, 9'h018, 16'hB010);
    i_req = '0;

    // Burst limit forces release and sets the timeout flag
    i_req = 3'b010;
    wait_gnt(1, -1, 0);
    write_burst(1, MB, 1'b0, 9'h100, 16'hC000);
    snap("timeout_set", K_TO, 0, 32'h2);
    snap("gnt_forced_off", K_GNT, 0, 0);
    i_req = '0;
    i_timeout_clr = 1'b1;
    @(posedge i_clk); #1;
    i_timeout_clr = 1'b0;
    snap("timeout_clr", K_TO, 0, 0);

    // Requester 2 drops its request with a write pending
    i_req = 3'b101;
    wait_gnt(2, -1, 0);
    write_burst(2, 1, 1'b0, 9'h040, 16'hD000);
    i_req = 3'b001;
    i_we[2] = 1'b1;
    i_addr[2*AW +: AW] = 9'h041;
    i_din[2*DW +: DW] = 16'hD001;
    @(posedge i_clk); #1;
    i_we[2] = 1'b0;
    snap("drop_no_ce", K_CE, 0, 0);
    wait_gnt(0, -1, 2);
    write_burst(0, 1, 1'b1, 9'h050, 16'hD100);
    i_req = '0;

    // Asynchronous reset during the third write
    i_req = 3'b001;
    wait_gnt(0, -1, 0);
    write_burst(0, 2, 1'b0, 9'h060, 16'hE000);
    i_we[0] = 1'b1;
    i_addr[0 +: AW] = 9'h062;
    i_din[0 +: DW] = 16'hE002;
    #6;
    i_rst = 1'b1;
    #1;
    snap("async_rst_gnt", K_GNT, 0, 0);
    snap("async_rst_ce", K_CE, 0, 0);
    snap("async_rst_addr", K_ADDR, 0, 0);
    snap("async_rst_din", K_DIN, 0, 0);
    i_we[0] = 1'b0;
    @(posedge i_clk); #1;
    i_rst = 1'b0;
    i_req = 3'b111;
    wait_gnt(0, 1, 0);
    write_burst(0, 1, 1'b1, 9'h070, 16'hE100);
    i_req = '0;

`ifdef XINTF_ARB_PRIORITY_EN
    // Requester 0 jumps the queue only once the active burst finishes
    repeat (3) @(posedge i_clk);
    #1;
    i_req = 3'b010;
    wait_gnt(1, -1, 0);
    i_req = 3'b111;
    write_burst(1, 2, 1'b1, 9'h080, 16'hF000);
    wait_gnt(0, -1, 2);
    write_burst(0, 1, 1'b1, 9'h090, 16'hF100);
    i_req = 3'b100;
    wait_gnt(2, -1, 2);
    write_burst(2, 1, 1'b1, 9'h0A0, 16'hF200);
    i_req = '0;
`endif

    repeat (4) @(posedge i_clk);
    #1;
    snap("writes_left", K_VAL, 32'(wr_q.size()), 0);
    snap("grants_left", K_VAL, 32'(g_q.size()), 0);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
